// File: rtl/utoss_riscv_pkg.sv
// Shared constants and helpers for the UTOSS multicycle RV32I core.
// Opcodes, FSM state encodings, ALU operation and immediate-format types.
package utoss_riscv_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [5:0] FETCH    = 6'd0;
  localparam logic [5:0] DECODE   = 6'd1;
  localparam logic [5:0] EXECUTEI = 6'd2;
  localparam logic [5:0] EXECUTER = 6'd3;
  localparam logic [5:0] MEMADR   = 6'd4;
  localparam logic [5:0] MEMREAD  = 6'd5;
  localparam logic [5:0] MEMWB    = 6'd6;
  localparam logic [5:0] MEMWRITE = 6'd7;
  localparam logic [5:0] ALUWB    = 6'd8;
  localparam logic [5:0] BRANCH   = 6'd9;
  localparam logic [5:0] JAL      = 6'd10;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;

  typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_STORE:  fmt = ImmS;
      OP_BRANCH: fmt = ImmB;
      OP_LUI:    fmt = ImmU;
      OP_JAL:    fmt = ImmJ;
      default:   fmt = ImmI;
    endcase
    return fmt;
  endfunction

  // SUB only exists for register operands; funct7[5] on shifts picks arithmetic.
  function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic funct7_5,
                                        input logic is_reg);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_reg && funct7_5) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = funct7_5 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/utoss_riscv_alu.sv
// 32-bit integer ALU; shifts use only the low five bits of b.
module utoss_riscv_alu
  import utoss_riscv_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_out
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;

  assign a = i_a;
  assign b = i_b;

  always_comb begin
    out = '0;
    case (i_op)
      AluAdd:  out = a + b;
      AluSub:  out = a - b;
      AluSll:  out = a << b[4:0];
      AluSlt:  out = {31'd0, $signed(a) < $signed(b)};
      AluSltu: out = {31'd0, a < b};
      AluXor:  out = a ^ b;
      AluSrl:  out = a >> b[4:0];
      AluSra:  out = $unsigned($signed(a) >>> b[4:0]);
      AluOr:   out = a | b;
      AluAnd:  out = a & b;
      default: out = '0;
    endcase
  end

  assign o_out = out;

endmodule

// File: rtl/utoss_riscv_control_fsm.sv
// Multicycle sequencer: one state per instruction phase, next state from the opcode.
module utoss_riscv_control_fsm
  import utoss_riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_opcode,
  output logic [5:0] o_state
);

  logic [5:0] current_state;
  logic [5:0] w_next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_state <= FETCH;
    end else begin
      current_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = FETCH;
    case (current_state)
      FETCH: w_next_state = DECODE;
      DECODE: begin
        case (i_opcode)
          OP_IMM:             w_next_state = EXECUTEI;
          OP_REG:             w_next_state = EXECUTER;
          OP_LOAD, OP_STORE:  w_next_state = MEMADR;
          OP_BRANCH:          w_next_state = BRANCH;
          OP_JAL:             w_next_state = JAL;
          OP_LUI:             w_next_state = ALUWB;
          default:            w_next_state = FETCH;
        endcase
      end
      EXECUTEI, EXECUTER: w_next_state = ALUWB;
      MEMADR:  w_next_state = (i_opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD: w_next_state = MEMWB;
      default: w_next_state = FETCH;
    endcase
  end

  assign o_state = current_state;

endmodule

// File: rtl/utoss_riscv_core.sv
// Multicycle RV32I datapath: sequencer, fetch, decode, register file and ALU,
// with operand/result latches between phases.
module utoss_riscv_core
  import utoss_riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata
);

  logic [5:0]  w_state;
  logic [6:0]  opcode;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic [31:0] w_imm_ext, w_instr, w_pc_cur, w_old_pc;
  logic [31:0] w_rd1, w_rd2, w_alu_a, w_alu_b, w_alu_out, w_rf_wd;
  alu_op_e     w_alu_op;
  logic        w_rf_we, w_taken, w_pc_load;
  logic [31:0] r_a, r_b, r_alu_out, r_data;

  utoss_riscv_control_fsm control_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_opcode (opcode),
    .o_state  (w_state)
  );

  utoss_riscv_fetch #(.RESET_PC(RESET_PC)) fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fetch     (w_state == FETCH),
    .i_pc_load   (w_pc_load),
    .i_pc_target (w_alu_out),
    .i_mem_rdata (i_mem_rdata),
    .o_pc_cur    (w_pc_cur),
    .o_old_pc    (w_old_pc),
    .o_instr     (w_instr)
  );

  utoss_riscv_decode instruction_decode (
    .i_instr    (w_instr),
    .o_opcode   (opcode),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_rd       (w_rd),
    .o_funct3   (w_funct3),
    .o_funct7_5 (w_funct7_5),
    .o_imm_ext  (w_imm_ext)
  );

  utoss_riscv_regfile RegFile (
    .clk   (clk),
    .i_rs1 (w_rs1),
    .i_rs2 (w_rs2),
    .i_rd  (w_rd),
    .i_we  (w_rf_we),
    .i_wd  (w_rf_wd),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  utoss_riscv_alu alu (
    .i_a   (w_alu_a),
    .i_b   (w_alu_b),
    .i_op  (w_alu_op),
    .o_out (w_alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_data    <= '0;
    end else begin
      if (w_state == DECODE) begin
        r_a <= w_rd1;
        r_b <= w_rd2;
      end
      if ((w_state == EXECUTEI) || (w_state == EXECUTER) || (w_state == MEMADR)) begin
        r_alu_out <= w_alu_out;
      end
      if (w_state == MEMREAD) begin
        r_data <= i_mem_rdata;
      end
    end
  end

  // BRANCH/JAL reuse the ALU adder for the old_pc + imm target.
  always_comb begin
    w_alu_a  = r_a;
    w_alu_b  = w_imm_ext;
    w_alu_op = AluAdd;
    case (w_state)
      EXECUTEI: w_alu_op = alu_op_of(w_funct3, w_funct7_5, 1'b0);
      EXECUTER: begin
        w_alu_b  = r_b;
        w_alu_op = alu_op_of(w_funct3, w_funct7_5, 1'b1);
      end
      BRANCH, JAL: w_alu_a = w_old_pc;
      default: ;
    endcase
  end

  assign w_taken   = ((w_funct3 == 3'b000) && (r_a == r_b)) ||
                     ((w_funct3 == 3'b001) && (r_a != r_b));
  assign w_pc_load = ((w_state == BRANCH) && w_taken) || (w_state == JAL);

  assign w_rf_we = (w_state == ALUWB) || (w_state == MEMWB) || (w_state == JAL);

  always_comb begin
    w_rf_wd = r_alu_out;
    case (w_state)
      ALUWB:   if (opcode == OP_LUI) w_rf_wd = w_imm_ext;
      MEMWB:   w_rf_wd = r_data;
      JAL:     w_rf_wd = w_old_pc + 32'd4;
      default: ;
    endcase
  end

  assign o_mem_addr  = (w_state == FETCH) ? w_pc_cur : r_alu_out;
  assign o_mem_we    = (w_state == MEMWRITE);
  assign o_mem_wdata = r_b;

endmodule

// File: rtl/utoss_riscv_decode.sv
// Combinational field extraction and sign-extended immediate generation.
module utoss_riscv_decode
  import utoss_riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic        o_funct7_5,
  output logic [31:0] o_imm_ext
);

  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [31:0] imm_ext;
  imm_fmt_e    w_fmt;

  assign rs1   = i_instr[19:15];
  assign rd    = i_instr[11:7];
  assign w_fmt = imm_fmt_of(i_instr[6:0]);

  always_comb begin
    imm_ext = {{20{i_instr[31]}}, i_instr[31:20]};
    case (w_fmt)
      ImmS: imm_ext = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      ImmB: imm_ext = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                       i_instr[11:8], 1'b0};
      ImmU: imm_ext = {i_instr[31:12], 12'b0};
      ImmJ: imm_ext = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                       i_instr[30:21], 1'b0};
      default: ;
    endcase
  end

  assign o_opcode   = i_instr[6:0];
  assign o_rs1      = rs1;
  assign o_rs2      = i_instr[24:20];
  assign o_rd       = rd;
  assign o_funct3   = i_instr[14:12];
  assign o_funct7_5 = i_instr[30];
  assign o_imm_ext  = imm_ext;

endmodule

// File: rtl/utoss_riscv_fetch.sv
// Program counter and instruction register; also remembers the PC of the
// instruction in flight for branch/JAL targets and link values.
module utoss_riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch,
  input  logic        i_pc_load,
  input  logic [31:0] i_pc_target,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_pc_cur,
  output logic [31:0] o_old_pc,
  output logic [31:0] o_instr
);

  logic [31:0] pc_cur;
  logic [31:0] r_old_pc;
  logic [31:0] r_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_cur   <= RESET_PC;
      r_old_pc <= RESET_PC;
      r_instr  <= '0;
    end else if (i_fetch) begin
      r_instr  <= i_mem_rdata;
      r_old_pc <= pc_cur;
      pc_cur   <= pc_cur + 32'd4;
    end else if (i_pc_load) begin
      pc_cur <= i_pc_target;
    end
  end

  assign o_pc_cur = pc_cur;
  assign o_old_pc = r_old_pc;
  assign o_instr  = r_instr;

endmodule

// File: rtl/utoss_riscv_memory.sv
// Unified instruction/data RAM: combinational read, synchronous write.
// Addresses are word-granular and wrap modulo MEM_WORDS.
module utoss_riscv_memory #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   M [0:MEM_WORDS-1];
  logic [AW-1:0] w_idx;

  assign w_idx = AW'((i_addr >> 2) % MEM_WORDS);

  always_ff @(posedge clk) begin
    if (i_we) begin
      M[w_idx] <= i_wdata;
    end
  end

  assign o_rdata = M[w_idx];

endmodule

// File: rtl/utoss_riscv_regfile.sv
// 32x32 register file, two async read ports, one sync write port.
// Contents are deliberately not reset so preloaded values survive reset.
module utoss_riscv_regfile (
  input  logic        clk,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_we,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] RFMem [0:31];

  always_ff @(posedge clk) begin
    if (i_we && (i_rd != 5'd0)) begin
      RFMem[i_rd] <= i_wd;
    end
  end

  assign o_rd1 = (i_rs1 == 5'd0) ? 32'd0 : RFMem[i_rs1];
  assign o_rd2 = (i_rs2 == 5'd0) ? 32'd0 : RFMem[i_rs2];

endmodule

// File: rtl/utoss_riscv.sv
// UTOSS multicycle RV32I top: core plus unified memory; clock and reset only.
module utoss_riscv #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic clk,
  input  logic reset
);

  logic [31:0] w_mem_addr;
  logic        w_mem_we;
  logic [31:0] w_mem_wdata;
  logic [31:0] w_mem_rdata;

  utoss_riscv_core #(.RESET_PC(RESET_PC)) core (
    .clk         (clk),
    .rst_n       (reset),
    .i_mem_rdata (w_mem_rdata),
    .o_mem_addr  (w_mem_addr),
    .o_mem_we    (w_mem_we),
    .o_mem_wdata (w_mem_wdata)
  );

  utoss_riscv_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk     (clk),
    .i_addr  (w_mem_addr),
    .i_we    (w_mem_we),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_utoss_riscv.sv
// Directed bench for utoss_riscv: single-instruction vector table plus
// hand-written multi-instruction sequences probing internal hierarchy.
module tb_utoss_riscv;

  localparam logic [5:0] S_FETCH    = 6'd0;
  localparam logic [5:0] S_DECODE   = 6'd1;
  localparam logic [5:0] S_EXECUTEI = 6'd2;
  localparam logic [5:0] S_MEMWB    = 6'd6;
  localparam logic [5:0] S_MEMWRITE = 6'd7;
  localparam logic [5:0] S_ALUWB    = 6'd8;
  localparam logic [5:0] S_BRANCH   = 6'd9;

  logic clk = 1'b0;
  logic reset;
  int   n_checks;
  int   n_fail;

  always #5 clk = ~clk;

  utoss_riscv dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] mem2;
    int          cycles;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          chk_fsm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [31:0] instr,
                              input logic [31:0] x1, input logic [31:0] x2,
                              input logic [31:0] mem2, input int cycles,
                              input logic [4:0] rd, input logic [31:0] exp, input bit chk);
    vec_t v;
    v.name = name; v.instr = instr; v.x1 = x1; v.x2 = x2; v.mem2 = mem2;
    v.cycles = cycles; v.rd = rd; v.exp = exp; v.chk_fsm = chk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset, wipe program/data and registers; x3..x5 get a marker value.
  task automatic prep();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      dut.memory.M[i] = 32'h0;
      dut.core.RegFile.RFMem[i] = 32'h0;
    end
    for (int i = 3; i < 6; i++) dut.core.RegFile.RFMem[i] = 32'hDEADBEEF;
  endtask

  initial begin
    reset    = 1'b0;
    n_checks = 0;
    n_fail   = 0;

    vecs.push_back(mk("add",      32'h002081B3, 32'd5,        32'd7,        0, 4, 3, 32'd12,       1));
    vecs.push_back(mk("sub",      32'h402081B3, 32'd5,        32'd7,        0, 4, 3, 32'hFFFFFFFE, 1));
    vecs.push_back(mk("and",      32'h0020F1B3, 32'hF0F000FF, 32'h0FF00F0F, 0, 4, 3, 32'h00F0000F, 1));
    vecs.push_back(mk("or",       32'h0020E1B3, 32'hF0F000FF, 32'h0FF00F0F, 0, 4, 3, 32'hFFF00FFF, 1));
    vecs.push_back(mk("xor",      32'h0020C1B3, 32'hF0F000FF, 32'h0FF00F0F, 0, 4, 3, 32'hFF000FF0, 1));
    vecs.push_back(mk("slt",      32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        0, 4, 3, 32'd1,        1));
    vecs.push_back(mk("sltu",     32'h0020B1B3, 32'hFFFFFFFF, 32'd1,        0, 4, 3, 32'd0,        1));
    vecs.push_back(mk("sll",      32'h002091B3, 32'd1,        32'h24,       0, 4, 3, 32'h10,       1));
    vecs.push_back(mk("srl",      32'h0020D1B3, 32'h80000000, 32'd4,        0, 4, 3, 32'h08000000, 1));
    vecs.push_back(mk("sra",      32'h4020D1B3, 32'h80000000, 32'd4,        0, 4, 3, 32'hF8000000, 1));
    vecs.push_back(mk("addi_m8",  32'hFF808193, 32'd10,       32'd0,        0, 4, 3, 32'd2,        1));
    vecs.push_back(mk("addi_wrap",32'h00108193, 32'hFFFFFFFF, 32'd0,        0, 4, 3, 32'd0,        1));
    vecs.push_back(mk("slti",     32'h0050A193, 32'hFFFFFFFD, 32'd0,        0, 4, 3, 32'd1,        1));
    vecs.push_back(mk("sltiu",    32'hFFF0B193, 32'd5,        32'd0,        0, 4, 3, 32'd1,        1));
    vecs.push_back(mk("xori",     32'hFFF0C193, 32'h12345678, 32'd0,        0, 4, 3, 32'hEDCBA987, 1));
    vecs.push_back(mk("srai",     32'h4040D193, 32'h80000000, 32'd0,        0, 4, 3, 32'hF8000000, 1));
    vecs.push_back(mk("lui",      32'h123451B7, 32'd0,        32'd0,        0, 4, 3, 32'h12345000, 0));
    vecs.push_back(mk("lw_wrap",  32'h0000A283, 32'h00001008, 32'd0, 32'h5A5A1234, 5, 5, 32'h5A5A1234, 1));
    vecs.push_back(mk("lw_neg",   32'hFFC0A283, 32'h0000000C, 32'd0, 32'hCAFEF00D, 5, 5, 32'hCAFEF00D, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      prep();
      dut.memory.M[0] = vecs[i].instr;
      dut.memory.M[2] = vecs[i].mem2;
      dut.core.RegFile.RFMem[1] = vecs[i].x1;
      dut.core.RegFile.RFMem[2] = vecs[i].x2;
      reset = 1'b1;
      tick(vecs[i].cycles);
      check($sformatf("%s rd", vecs[i].name), dut.core.RegFile.RFMem[vecs[i].rd], vecs[i].exp);
      if (vecs[i].chk_fsm)
        check($sformatf("%s state", vecs[i].name),
              32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
    end

    // Three addi instructions reading x2 into x1.
    prep();
    dut.memory.M[0] = 32'h00010093;
    dut.memory.M[1] = 32'h00410093;
    dut.memory.M[2] = 32'hFF810093;
    dut.core.RegFile.RFMem[2] = 32'd42;
    check("rst state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
    check("rst pc", dut.core.fetch.pc_cur, 32'h0);
    reset = 1'b1;
    tick(1);
    check("dec state", 32'(dut.core.control_fsm.current_state), 32'(S_DECODE));
    check("dec opcode", 32'(dut.core.opcode), 32'h13);
    check("dec rs1", 32'(dut.core.instruction_decode.rs1), 32'd2);
    check("dec rd", 32'(dut.core.instruction_decode.rd), 32'd1);
    check("dec imm", dut.core.instruction_decode.imm_ext, 32'd0);
    tick(1);
    check("exi state", 32'(dut.core.control_fsm.current_state), 32'(S_EXECUTEI));
    check("exi alu.a", dut.core.alu.a, 32'd42);
    check("exi alu.b", dut.core.alu.b, 32'd0);
    tick(1);
    check("wb state", 32'(dut.core.control_fsm.current_state), 32'(S_ALUWB));
    check("x1 before wb", dut.core.RegFile.RFMem[1], 32'd0);
    tick(1);
    check("i1 state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
    check("i1 x1", dut.core.RegFile.RFMem[1], 32'd42);
    check("i1 pc", dut.core.fetch.pc_cur, 32'd4);
    tick(1);
    check("i2 imm", dut.core.instruction_decode.imm_ext, 32'd4);
    tick(3);
    check("i2 x1", dut.core.RegFile.RFMem[1], 32'd46);
    check("i2 pc", dut.core.fetch.pc_cur, 32'd8);
    tick(2);
    check("i3 imm -8", dut.core.instruction_decode.imm_ext, 32'hFFFFFFF8);
    check("i3 alu.b", dut.core.alu.b, 32'hFFFFFFF8);
    tick(2);
    check("i3 x1", dut.core.RegFile.RFMem[1], 32'd34);
    check("i3 pc", dut.core.fetch.pc_cur, 32'd12);
    check("x2 kept", dut.core.RegFile.RFMem[2], 32'd42);

    // sw x2,8(x0) then lw x4,8(x0).
    prep();
    dut.memory.M[0] = 32'h00202423;
    dut.memory.M[1] = 32'h00802203;
    dut.core.RegFile.RFMem[2] = 32'd7;
    reset = 1'b1;
    tick(3);
    check("sw state", 32'(dut.core.control_fsm.current_state), 32'(S_MEMWRITE));
    check("sw M2 early", dut.memory.M[2], 32'd0);
    tick(1);
    check("sw M2", dut.memory.M[2], 32'd7);
    check("sw pc", dut.core.fetch.pc_cur, 32'd4);
    tick(4);
    check("lw state", 32'(dut.core.control_fsm.current_state), 32'(S_MEMWB));
    check("lw x4 early", dut.core.RegFile.RFMem[4], 32'hDEADBEEF);
    tick(1);
    check("lw x4", dut.core.RegFile.RFMem[4], 32'd7);
    check("lw pc", dut.core.fetch.pc_cur, 32'd8);

    // addi x0 (ignored), addi x1, beq back to pc 4.
    prep();
    dut.memory.M[0] = 32'h00500013;
    dut.memory.M[1] = 32'h00108093;
    dut.memory.M[2] = 32'hFE000EE3;
    reset = 1'b1;
    tick(4);
    check("x0 stays 0", dut.core.RegFile.RFMem[0], 32'd0);
    tick(4);
    check("loop x1 a", dut.core.RegFile.RFMem[1], 32'd1);
    tick(2);
    check("beq state", 32'(dut.core.control_fsm.current_state), 32'(S_BRANCH));
    tick(1);
    check("beq pc", dut.core.fetch.pc_cur, 32'd4);
    tick(4);
    check("loop x1 b", dut.core.RegFile.RFMem[1], 32'd2);

    // bne not taken, then jal x1,+12 from pc 4.
    prep();
    dut.memory.M[0] = 32'h00001463;
    dut.memory.M[1] = 32'h00C000EF;
    reset = 1'b1;
    tick(3);
    check("bne state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
    check("bne pc", dut.core.fetch.pc_cur, 32'd4);
    tick(3);
    check("jal pc", dut.core.fetch.pc_cur, 32'd16);
    check("jal x1", dut.core.RegFile.RFMem[1], 32'd8);

    // Reset during EXECUTEI must abort without writing rd.
    prep();
    dut.memory.M[0] = 32'h00410093;
    dut.core.RegFile.RFMem[1] = 32'h11111111;
    dut.core.RegFile.RFMem[2] = 32'd42;
    reset = 1'b1;
    tick(2);
    check("mid state", 32'(dut.core.control_fsm.current_state), 32'(S_EXECUTEI));
    reset = 1'b0;
    #1;
    check("abort state", 32'(dut.core.control_fsm.current_state), 32'(S_FETCH));
    check("abort pc", dut.core.fetch.pc_cur, 32'd0);
    @(negedge clk);
    check("abort x1", dut.core.RegFile.RFMem[1], 32'h11111111);
    reset = 1'b1;
    tick(4);
    check("rerun x1", dut.core.RegFile.RFMem[1], 32'd46);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
